aes_word_buffer: RTL

- Sits between the AHB-lite slave interface and the AES controller/datapath. It has two independent halves.
- Ingress: packs four 32-bit bus words into one 128-bit block, tags it as key or data, and presents it to the controller with a valid/ack handshake.
- Egress: takes a 128-bit result block from the AES core and drains it to the bus as four 32-bit words.
- Provides backpressure and flags protocol errors, which drive the controller's ERROR state.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_word_ser.sv | 82 ++++++++
 rtl/aes_word_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES bus-side word buffer.
// Both halves move 128-bit blocks as four 32-bit bus words, word 0 in the top slice.
package aes_pkg;
  localparam int WORD_W = 32;
  localparam int WORDS  = 4;
  localparam int BLK_W  = WORD_W * WORDS;

  typedef enum logic {FILL, FULL} ing_state_t;
  typedef enum logic {EMPTY, DRAIN} egr_state_t;

  typedef logic [127:0] aes_blk_t;
endpackage

// File: rtl/aes_word_ser.sv
// Egress serializer: holds one result block and presents it to the bus one word
// at a time, word 0 first. overrun flags a result offered while still draining.
module aes_word_ser #(
  parameter int WORD_W = aes_pkg::WORD_W,
  parameter int WORDS  = aes_pkg::WORDS
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      load,
  input  logic [WORD_W*WORDS-1:0]   data_in,
  input  logic                      rd_en,
  output logic [WORD_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      overrun
);
  import aes_pkg::*;

  localparam int BLK_W = WORD_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  egr_state_t       state;
  egr_state_t       state_nxt;
  logic [CNT_W-1:0] idx;
  logic [BLK_W-1:0] blk;
  logic             pop;
  logic             last_pop;
  logic             take;

  function automatic logic [WORD_W-1:0] word_at(input logic [BLK_W-1:0] b,
                                                input logic [CNT_W-1:0] i);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < WORDS; k++)
      if (i == CNT_W'(k)) w = b[BLK_W-1-k*WORD_W -: WORD_W];
    return w;
  endfunction

  assign pop      = rd_en && (state == DRAIN);
  assign last_pop = pop && (idx == LAST);
  // A new result may land on the very cycle the last word leaves.
  assign take     = load && ((state == EMPTY) || last_pop);
  assign overrun  = load && (state == DRAIN) && !last_pop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     state <= EMPTY;
    else if (clear) state <= EMPTY;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = DRAIN;
      DRAIN:   if (last_pop && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx <= '0;
      blk <= '0;
    end else if (clear) begin
      idx <= '0;
      blk <= '0;
    end else if (take) begin
      idx <= '0;
      blk <= data_in;
    end else if (pop) begin
      idx <= last_pop ? '0 : idx + CNT_W'(1);
    end
  end

  always_comb begin
    rd_valid = (state == DRAIN);
    busy     = (state == DRAIN);
    rd_data  = rd_valid ? word_at(blk, idx) : '0;
  end
endmodule

// File: rtl/aes_word_buffer.sv
// Bus-side word buffer for the AES core: packs ingress words into tagged key/data
// blocks for the controller and serializes result blocks back onto the bus.
module aes_word_buffer #(
  parameter int WORD_W = aes_pkg::WORD_W,
  parameter int WORDS  = aes_pkg::WORDS
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      wr_valid,
  input  logic [WORD_W-1:0]         wr_data,
  input  logic                      wr_is_key,
  output logic                      wr_ready,
  output logic                      blk_valid,
  output logic [WORD_W*WORDS-1:0]   blk_data,
  output logic                      blk_is_key,
  input  logic                      blk_ack,
  input  logic                      res_load,
  input  logic [WORD_W*WORDS-1:0]   res_data,
  output logic                      res_busy,
  input  logic                      rd_en,
  output logic [WORD_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      err
);
  import aes_pkg::*;

  localparam int BLK_W = WORD_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  ing_state_t       state;
  ing_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] slot;
  logic [BLK_W-1:0] blk_reg;
  logic             blk_type;
  logic             accept;
  logic             mismatch;
  logic             restart;
  logic             last_word;
  logic             overrun;
  logic             err_reg;

  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0]  b,
                                                input logic [CNT_W-1:0]  i,
                                                input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] r;
    r = b;
    for (int k = 0; k < WORDS; k++)
      if (i == CNT_W'(k)) r[BLK_W-1-k*WORD_W -: WORD_W] = w;
    return r;
  endfunction

  assign accept    = wr_valid && (state == FILL);
  // A word of the wrong type abandons the partial block and starts a new one.
  assign mismatch  = accept && (cnt != '0) && (wr_is_key != blk_type);
  assign restart   = accept && ((cnt == '0) || mismatch);
  assign slot      = restart ? '0 : cnt;
  assign last_word = accept && (slot == LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     state <= FILL;
    else if (clear) state <= FILL;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (last_word) state_nxt = FULL;
      FULL:    if (blk_ack) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt      <= '0;
      blk_reg  <= '0;
      blk_type <= 1'b0;
    end else if (clear) begin
      cnt      <= '0;
      blk_reg  <= '0;
      blk_type <= 1'b0;
    end else if (accept) begin
      blk_reg <= put_word(blk_reg, slot, wr_data);
      cnt     <= last_word ? '0 : slot + CNT_W'(1);
      if (restart) blk_type <= wr_is_key;
    end
  end

  always_comb begin
    wr_ready   = (state == FILL);
    blk_valid  = (state == FULL);
    blk_data   = blk_reg;
    blk_is_key = blk_type;
  end

  aes_word_ser #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_ser (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .load     (res_load),
    .data_in  (res_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (res_busy),
    .overrun  (overrun)
  );

  // Both halves report through one registered single-cycle pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     err_reg <= 1'b0;
    else if (clear) err_reg <= 1'b0;
    else            err_reg <= mismatch | overrun;
  end

  assign err = err_reg;
endmodule
